// File: rtl/seq_unsigned_multiplier_if.sv
// Operand/result bundle for seq_unsigned_multiplier.
// The overflow signal exists only when MULT_OVERFLOW_FLAG_EN is defined.
interface seq_unsigned_multiplier_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             done;
`ifdef MULT_OVERFLOW_FLAG_EN
    logic             overflow;

    modport master (
        output start, a, b,
        input  result, done, overflow
    );

    modport slave (
        input  start, a, b,
        output result, done, overflow
    );
`else
    modport master (
        output start, a, b,
        input  result, done
    );

    modport slave (
        input  start, a, b,
        output result, done
    );
`endif
endinterface

// File: rtl/seq_unsigned_multiplier.sv
// Shift-and-add unsigned multiplier, one multiplier bit per clock, product mod 2^WIDTH.
// Optional feature macro: MULT_OVERFLOW_FLAG_EN adds a sticky full-product overflow flag.
module seq_unsigned_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    seq_unsigned_multiplier_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rega_q, rega_d;
    logic [WIDTH-1:0] regb_q, regb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] adder_out;
    logic [WIDTH-1:0] carry;

    // Ripple-carry chain of full-adder cells: acc + regA. The carry out of the
    // top cell is only formed when the overflow flag needs it.
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign adder_out[i] = acc_q[i] ^ rega_q[i] ^ carry[i];
        if (i < WIDTH - 1) begin : g_carry
            assign carry[i+1] = (acc_q[i] & rega_q[i]) |
                                (carry[i] & (acc_q[i] ^ rega_q[i]));
        end
    end

`ifdef MULT_OVERFLOW_FLAG_EN
    logic add_cout;
    logic lost_q, lost_d;
    logic ovf_q, ovf_d;
    logic overflow_q, overflow_d;
    logic step_ovf;

    assign add_cout = (acc_q[WIDTH-1] & rega_q[WIDTH-1]) |
                      (carry[WIDTH-1] & (acc_q[WIDTH-1] ^ rega_q[WIDTH-1]));

    // lost_q remembers that a set multiplicand bit has been shifted past the
    // top; any later partial product then exceeds the range on its own.
    assign step_ovf = regb_q[0] & (add_cout | lost_q);
`endif

    always_comb begin
        state_d  = state_q;
        rega_d   = rega_q;
        regb_d   = regb_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        done_d   = done_q;
`ifdef MULT_OVERFLOW_FLAG_EN
        lost_d     = lost_q;
        ovf_d      = ovf_q;
        overflow_d = overflow_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    rega_d  = bus.a;
                    regb_d  = bus.b;
                    acc_d   = '0;
                    count_d = '0;
                    done_d  = 1'b0;
                    state_d = BUSY;
`ifdef MULT_OVERFLOW_FLAG_EN
                    lost_d     = 1'b0;
                    ovf_d      = 1'b0;
                    overflow_d = 1'b0;
`endif
                end
            end

            BUSY: begin
                if (regb_q[0]) begin
                    acc_d = adder_out;
                end
                rega_d  = rega_q << 1;
                regb_d  = regb_q >> 1;
                count_d = count_q + CNT_ONE;
`ifdef MULT_OVERFLOW_FLAG_EN
                lost_d = lost_q | rega_q[WIDTH-1];
                ovf_d  = ovf_q | step_ovf;
`endif
                if (count_q == LAST_ITER) begin
                    result_d = regb_q[0] ? adder_out : acc_q;
                    done_d   = 1'b1;
                    state_d  = DONE;
`ifdef MULT_OVERFLOW_FLAG_EN
                    overflow_d = ovf_q | step_ovf;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rega_q   <= '0;
            regb_q   <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rega_q   <= rega_d;
            regb_q   <= regb_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

`ifdef MULT_OVERFLOW_FLAG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lost_q     <= 1'b0;
            ovf_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            lost_q     <= lost_d;
            ovf_q      <= ovf_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.overflow = overflow_q;
`endif

    assign bus.result = result_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_seq_unsigned_multiplier.sv
// Self-checking bench for seq_unsigned_multiplier: directed edge cases plus
// random operands against a plain-arithmetic product model.
module tb_seq_unsigned_multiplier;

    localparam int WIDTH = 8;
    localparam int MODV  = 1 << WIDTH;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   prev_res;

    seq_unsigned_multiplier_if #(.WIDTH(WIDTH)) bus ();

    seq_unsigned_multiplier #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Load one operation, wait for done (bounded), compare with a*b mod 2^WIDTH.
    // With poke set, new operands and a start pulse arrive mid-operation.
    task automatic run_op(input int av, input int bv, input bit poke, input string tag);
        int exp_r;
        int exp_o;
        int lat;
        int ra;
        int rb;
        exp_r = (av * bv) % MODV;
        exp_o = ((av * bv) > (MODV - 1)) ? 1 : 0;
        lat   = 0;
        @(negedge clk);
        bus.a     = av[WIDTH-1:0];
        bus.b     = bv[WIDTH-1:0];
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk({tag, "/done_at_load"}, int'(bus.done), 0);
        for (int c = 1; c <= 20; c++) begin
            if (poke && c == 3) begin
                ra = $urandom_range(0, MODV - 1);
                rb = $urandom_range(0, MODV - 1);
                bus.a     = ra[WIDTH-1:0];
                bus.b     = rb[WIDTH-1:0];
                bus.start = 1'b1;
            end
            if (poke && c == 4) bus.start = 1'b0;
            @(posedge clk);
            #1;
            if (c == 3) chk({tag, "/result_held_busy"}, int'(bus.result), prev_res);
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        bus.start = 1'b0;
        chk({tag, "/latency"}, lat, WIDTH);
        chk({tag, "/result"}, int'(bus.result), exp_r);
`ifdef MULT_OVERFLOW_FLAG_EN
        chk({tag, "/overflow"}, int'(bus.overflow), exp_o);
`endif
        prev_res = exp_r;
    endtask

    task automatic hold_check(input int cycles, input string tag);
        repeat (cycles) @(posedge clk);
        #1;
        chk({tag, "/done_held"}, int'(bus.done), 1);
        chk({tag, "/result_held"}, int'(bus.result), prev_res);
    endtask

    initial begin
        int ra;
        int rb;
        n_cmp     = 0;
        n_err     = 0;
        prev_res  = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        #2;
        chk("reset/done", int'(bus.done), 0);
        chk("reset/result", int'(bus.result), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_op(5, 3, 1'b0, "5x3");
        hold_check(4, "5x3");

        run_op(0, 50, 1'b0, "0x50");
        run_op(25, 0, 1'b0, "25x0");
        run_op(1, 255, 1'b0, "1x255");
        run_op(255, 1, 1'b0, "255x1");

        run_op(255, 2, 1'b0, "255x2");
        run_op(128, 3, 1'b0, "128x3");
        run_op(100, 5, 1'b0, "100x5");
        run_op(255, 255, 1'b0, "255x255");
        run_op(12, 10, 1'b0, "12x10");

        run_op(85, 51, 1'b0, "85x51");
        run_op(170, 85, 1'b0, "170x85");
        run_op(3, 85, 1'b0, "3x85");
        run_op(64, 32, 1'b0, "64x32");

        run_op(13, 11, 1'b1, "poke13x11");
        hold_check(2, "poke13x11");

        // run_op returns on the done cycle, so this next load is back-to-back
        run_op(9, 9, 1'b0, "b2b_first");
        run_op(17, 6, 1'b0, "b2b_second");

        @(negedge clk);
        bus.a     = 8'd200;
        bus.b     = 8'd77;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst/done", int'(bus.done), 0);
        chk("midrst/result", int'(bus.result), 0);
`ifdef MULT_OVERFLOW_FLAG_EN
        chk("midrst/overflow", int'(bus.overflow), 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("midrst/done_hold", int'(bus.done), 0);
        @(negedge clk);
        rst      = 1'b1;
        prev_res = 0;
        run_op(7, 8, 1'b0, "7x8_after_rst");

        for (int i = 0; i < 20; i++) begin
            ra = $urandom_range(0, MODV - 1);
            rb = $urandom_range(0, MODV - 1);
            run_op(ra, rb, (i % 4) == 1, $sformatf("rand%0d_%0dx%0d", i, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
